// File: rtl/nios_cpu_debug_host_sequencer_if.sv
// Command/response handshake between a debug controller (master) and the
// Nios II debug-slave host sequencer (slave).
interface nios_cpu_debug_host_sequencer_if #(
  parameter int unsigned DR_LEN = 38
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_ir;
  logic [DR_LEN-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DR_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/nios_cpu_debug_host_sequencer.sv
// Virtual-JTAG initiator for the Nios II debug slave: one command in, runs
// UIR/CDR/SDR/UDR with a divided tck, returns the shifted-out tdo word.
module nios_cpu_debug_host_sequencer #(
  parameter int unsigned TCK_DIV = 2,
  parameter int unsigned DR_LEN  = 38
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  nios_cpu_debug_host_sequencer_if.slave        host,
  output logic                                  tck,
  output logic                                  tdi,
  input  logic                                  tdo,
  output logic [1:0]                            ir_in,
  output logic                                  vs_uir,
  output logic                                  vs_cdr,
  output logic                                  vs_sdr,
  output logic                                  vs_udr,
  output logic                                  jtag_state_rti
);
  localparam int unsigned PER  = 2 * TCK_DIV;
  localparam int unsigned PH_W = (PER > 2) ? $clog2(PER) : 1;
  localparam int unsigned BC_W = (DR_LEN > 2) ? $clog2(DR_LEN) : 1;

  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PER - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(TCK_DIV);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RSP
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   ph;
  logic [PH_W-1:0]   ph_nxt;
  logic [BC_W-1:0]   bcnt;
  logic [DR_LEN-1:0] sh;
  logic [DR_LEN-1:0] rsp_data_q;
  logic              tdo_s;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              period_end;
  logic              shift_bit;
  logic              active;

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

  assign ph_nxt     = ph + PH_ONE;
  assign period_end = (ph == PH_LAST);
  assign active     = (state == UIR) || (state == CDR) || (state == SDR) || (state == UDR);
  // With TCK_DIV=1 the rise cycle is also the last cycle, so the shift must
  // take tdo directly instead of the previously sampled copy.
  assign shift_bit  = (TCK_DIV == 1) ? tdo : tdo_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ph             <= '0;
      bcnt           <= '0;
      sh             <= '0;
      tdo_s          <= 1'b0;
      rsp_data_q     <= '0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      ir_in          <= '0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b1;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
    end else begin
      // Free-running divider across UIR..UDR keeps tck periodic at boundaries.
      if (active) begin
        if (period_end) begin
          ph  <= '0;
          tck <= 1'b0;
        end else begin
          ph  <= ph_nxt;
          tck <= (ph_nxt >= PH_RISE);
        end
      end

      if ((state == SDR) && (ph == PH_RISE)) begin
        tdo_s <= tdo;
      end

      case (state)
        IDLE: begin
          if (host.cmd_valid) begin
            state          <= UIR;
            ir_in          <= host.cmd_ir;
            sh             <= host.cmd_data;
            ph             <= '0;
            bcnt           <= '0;
            tck            <= 1'b0;
            vs_uir         <= 1'b1;
            jtag_state_rti <= 1'b0;
            cmd_ready_q    <= 1'b0;
          end
        end
        UIR: begin
          if (period_end) begin
            state  <= CDR;
            vs_uir <= 1'b0;
            vs_cdr <= 1'b1;
          end
        end
        CDR: begin
          if (period_end) begin
            state  <= SDR;
            vs_cdr <= 1'b0;
            vs_sdr <= 1'b1;
            tdi    <= sh[0];
          end
        end
        SDR: begin
          if (period_end) begin
            sh <= {shift_bit, sh[DR_LEN-1:1]};
            if (bcnt == BC_LAST) begin
              bcnt   <= '0;
              state  <= UDR;
              vs_sdr <= 1'b0;
              vs_udr <= 1'b1;
              tdi    <= 1'b0;
            end else begin
              bcnt <= bcnt + BC_ONE;
              tdi  <= sh[1];
            end
          end
        end
        UDR: begin
          if (period_end) begin
            state       <= RSP;
            vs_udr      <= 1'b0;
            rsp_data_q  <= sh;
            rsp_valid_q <= 1'b1;
          end
        end
        RSP: begin
          if (host.rsp_ready) begin
            state          <= IDLE;
            rsp_valid_q    <= 1'b0;
            cmd_ready_q    <= 1'b1;
            jtag_state_rti <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nios_cpu_debug_host_sequencer.sv
// Bench for nios_cpu_debug_host_sequencer: TCK_DIV=2 and TCK_DIV=1 instances
// checked cycle by cycle against a timing/data model of the command sequence.
module tb_nios_cpu_debug_host_sequencer;
  localparam int unsigned DR = 38;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          cv[2];
  logic [1:0]    cir[2];
  logic [DR-1:0] cdat[2];
  logic          rr[2];
  logic          tdo_v[2];

  logic          crdy_w[2], rval_w[2], tck_w[2], tdi_w[2];
  logic          uir_w[2], cdr_w[2], sdr_w[2], udr_w[2], rti_w[2];
  logic [1:0]    ir_w[2];
  logic [DR-1:0] rdat_w[2];

  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nios_cpu_debug_host_sequencer_if #(.DR_LEN(DR)) bus ();
    assign bus.cmd_valid = cv[g];
    assign bus.cmd_ir    = cir[g];
    assign bus.cmd_data  = cdat[g];
    assign bus.rsp_ready = rr[g];
    assign crdy_w[g]     = bus.cmd_ready;
    assign rval_w[g]     = bus.rsp_valid;
    assign rdat_w[g]     = bus.rsp_data;

    nios_cpu_debug_host_sequencer #(
      .TCK_DIV((g == 0) ? 2 : 1),
      .DR_LEN (DR)
    ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .host          (bus),
      .tck           (tck_w[g]),
      .tdi           (tdi_w[g]),
      .tdo           (tdo_v[g]),
      .ir_in         (ir_w[g]),
      .vs_uir        (uir_w[g]),
      .vs_cdr        (cdr_w[g]),
      .vs_sdr        (sdr_w[g]),
      .vs_udr        (udr_w[g]),
      .jtag_state_rti(rti_w[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DR-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DR-1:0];
  endfunction

  // {tck, vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, rti, cmd_ready, rsp_valid, ir_in}
  function automatic logic [10:0] obs_vec(input int s);
    return {tck_w[s], uir_w[s], cdr_w[s], sdr_w[s], udr_w[s], tdi_w[s],
            rti_w[s], crdy_w[s], rval_w[s], ir_w[s]};
  endfunction

  function automatic logic [10:0] idle_vec(input logic [1:0] ir);
    return {1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, ir};
  endfunction

  function automatic logic [10:0] rsp_vec(input logic [1:0] ir);
    return {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, ir};
  endfunction

  // Runs one command. loop=1 feeds tdi back as tdo, otherwise tdo follows pat
  // (bit i during the i-th shift period). abort_bit>=0 resets mid-SDR.
  task automatic run_cmd(input int sel, input logic [1:0] ir, input logic [DR-1:0] data,
                         input bit loop, input logic [DR-1:0] pat,
                         input int abort_bit, input int hold);
    int div, p, np;
    logic [DR-1:0] exp_rsp;
    logic [10:0] expv;
    div = (sel == 0) ? 2 : 1;
    p   = 2 * div;
    np  = (int'(DR) + 3) * p;
    exp_rsp = loop ? data : pat;

    @(negedge clk);
    check("accept_idle", 64'(obs_vec(sel)), 64'(idle_vec(ir_w[sel])));
    if (hold == 0) rr[sel] = 1'b1;
    cv[sel] = 1'b1; cir[sel] = ir; cdat[sel] = data;
    @(negedge clk);
    cv[sel] = 1'b0; cir[sel] = ~ir; cdat[sel] = rnd();

    for (int t = 0; t < np; t++) begin
      int per, ph, bi;
      bit sdr, tdi_exp;
      per = t / p;
      ph  = t % p;
      bi  = per - 2;
      sdr = (per >= 2) && (per < int'(DR) + 2);
      tdi_exp = 1'b0;
      tdo_v[sel] = 1'b0;
      if (sdr) begin
        tdi_exp = data[bi];
        tdo_v[sel] = loop ? tdi_w[sel] : pat[bi];
      end
      expv = {(ph >= div), (per == 0), (per == 1), sdr, (per == int'(DR) + 2),
              tdi_exp, 1'b0, 1'b0, 1'b0, ir};
      check($sformatf("seq%0d_t%0d", sel, t), 64'(obs_vec(sel)), 64'(expv));
      if (sdr && bi == abort_bit && ph == 0) begin
        reset_n = 1'b0;
        #1;
        check("abort_reset_vec", 64'(obs_vec(sel)), 64'(idle_vec(2'b00)));
        check("abort_reset_rsp", 64'(rdat_w[sel]), 64'(0));
        tdo_v[sel] = 1'b0;
        rr[sel] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_after_vec", 64'(obs_vec(sel)), 64'(idle_vec(2'b00)));
        return;
      end
      @(negedge clk);
    end
    tdo_v[sel] = 1'b0;

    check($sformatf("rsp_valid_lat%0d", sel), 64'(obs_vec(sel)), 64'(rsp_vec(ir)));
    check($sformatf("rsp_data%0d", sel), 64'(rdat_w[sel]), 64'(exp_rsp));
    for (int h = 0; h < hold; h++) begin
      cv[sel] = 1'b1; cir[sel] = ~ir; cdat[sel] = rnd();
      @(negedge clk);
      check("bp_vec", 64'(obs_vec(sel)), 64'(rsp_vec(ir)));
      check("bp_data", 64'(rdat_w[sel]), 64'(exp_rsp));
    end
    cv[sel] = 1'b0;
    rr[sel] = 1'b1;
    @(negedge clk);
    check($sformatf("back_idle%0d", sel), 64'(obs_vec(sel)), 64'(idle_vec(ir)));
    check("rsp_data_kept", 64'(rdat_w[sel]), 64'(exp_rsp));
    rr[sel] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      cv[s] = 1'b0; cir[s] = '0; cdat[s] = '0; rr[s] = 1'b0; tdo_v[s] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_vec", 64'(obs_vec(s)), 64'(idle_vec(2'b00)));
      check("reset_rsp_data", 64'(rdat_w[s]), 64'(0));
    end
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_activity0", 64'(obs_vec(0)), 64'(idle_vec(2'b00)));
      check("no_activity1", 64'(obs_vec(1)), 64'(idle_vec(2'b00)));
    end

    // Loopback, alternating pattern, rsp_ready already high.
    run_cmd(0, 2'b01, 38'h2A_AAAA_AAAA, 1'b1, '0, -1, 0);
    // tdo tied high, zero data, then 20 cycles of backpressure.
    run_cmd(0, 2'b10, '0, 1'b0, '1, -1, 20);
    // Second command accepted after the backpressured response.
    run_cmd(0, 2'b11, rnd(), 1'b1, '0, -1, 0);
    // Reset during SDR bit 17, then a full command.
    run_cmd(0, 2'b10, rnd(), 1'b1, '0, 17, 0);
    run_cmd(0, 2'b01, 38'h12_3456_789A, 1'b1, '0, -1, 0);
    // TCK_DIV=1 loopback.
    run_cmd(1, 2'b01, 38'h00_0000_0001, 1'b1, '0, -1, 0);

    for (int k = 0; k < 8; k++) begin
      int sel, hold;
      logic [1:0] ir;
      bit loop;
      sel  = int'($urandom_range(0, 1));
      ir   = 2'($urandom_range(0, 3));
      loop = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 3));
      run_cmd(sel, ir, rnd(), loop, rnd(), -1, hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/nios_cpu_debug_host_sequencer.md
# nios_cpu_debug_host_sequencer

Single-clock initiator for the Nios II CPU debug-slave virtual-JTAG link. It accepts one debug command at a time, made of a 2-bit instruction and a 38-bit data word. For each command it generates the virtual TAP sequence that the CPU-side debug slave consumes: update-IR, capture-DR, a 38-bit serial shift and update-DR. The bits returned on tdo are assembled into a response word. It sits on the system side, between an on-chip debug controller/test harness and the debug-slave TCK logic, replacing the sld_virtual_jtag_basic hub when driving the debug slave internally.

## Interface
Parameters:
- TCK_DIV, 2: clk cycles per tck half-period; legal range >=1. One tck period P = 2*TCK_DIV clk cycles.
- DR_LEN, 38: shift length in bits; equals the data width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid&cmd_ready
- cmd_ir  in  2  instruction, latched on accept
- cmd_data  in  DR_LEN  shift-in data, latched on accept
- rsp_valid  out  1  response available; held until accepted
- rsp_ready  in  1  response accept
- rsp_data  out  DR_LEN  captured tdo word; stable while rsp_valid
- tck  out  1  generated test clock
- tdi  out  1  serial data to the slave
- tdo  in  1  serial data from the slave
- ir_in  out  2  instruction to the slave
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1  virtual state strobes
- jtag_state_rti  out  1  run-test-idle indicator

## Operation
- States: IDLE -> UIR -> CDR -> SDR -> UDR -> RSP -> IDLE.
- IDLE:
  - cmd_ready=1, jtag_state_rti=1, tck held 0.
  - On accept, latch cmd_ir into ir_in and cmd_data into the shift register sh[DR_LEN-1:0].
  - Start the tck divider at phase 0.
- Each state except IDLE/RSP lasts whole tck periods.
  - Each period: tck=0 for the first TCK_DIV cycles and 1 for the second TCK_DIV cycles.
- UIR: 1 period, vs_uir=1.
- CDR: 1 period, vs_cdr=1.
- SDR: DR_LEN periods, vs_sdr=1.
  - tdi=sh[0] throughout each period.
  - At the last clk cycle of each period: sh <= {tdo_s, sh[DR_LEN-1:1]}, where tdo_s is tdo sampled on the clk cycle tck rises (0->1).
  - Bit count uses a counter 0..DR_LEN-1; leave SDR after count DR_LEN-1.
- UDR: 1 period, vs_udr=1. At its end, rsp_data <= sh.
- RSP: rsp_valid=1, tck=0, strobes 0. Return to IDLE on rsp_ready.
  - cmd_ready stays 0 in RSP, so a new command cannot be accepted in the same cycle as the response.
- Only one strobe is ever high at a time. Strobes are 0 in IDLE and RSP.
- ir_in holds its value from accept until the next accept; it is not cleared in IDLE.
- cmd_valid is ignored while not in IDLE; command inputs are not sampled after accept.
- tdi=0 outside SDR.

## Timing
- Reset (async assert, any state):
  - State goes to IDLE; divider and bit counter cleared.
  - tck=0, tdi=0, ir_in=0, all strobes 0, jtag_state_rti=1, cmd_ready=1, rsp_valid=0, rsp_data=0, sh=0.
- Reset mid-operation aborts the command with no response. The first command after deassertion runs a full sequence.
- Accept at edge N:
  - UIR is visible from cycle N+1.
  - rsp_valid rises at cycle N+1+(DR_LEN+3)*P.
  - Example: TCK_DIV=2, DR_LEN=38 gives P=4, so rsp_valid rises 164 cycles after accept.
- jtag_state_rti falls in the cycle after accept and rises on return to IDLE.
- tck is strictly periodic from UIR through UDR; no glitches at state boundaries.
- tdo is sampled once per SDR period, exactly on the tck rising cycle.
- rsp_valid with rsp_ready already high: one RSP cycle, then IDLE, and cmd_ready=1 the following cycle.
- TCK_DIV=1: P=2. tck rises on the second cycle of each period, and sampling and shift happen on that same cycle.

## Test plan
- Reset: hold reset_n=0 -> cmd_ready=1, jtag_state_rti=1, tck=0, rsp_valid=0, ir_in=0, rsp_data=0; release -> no activity without cmd_valid.
- Loopback tdo=tdi, cmd_ir=2'b01, cmd_data=38'h2A_AAAA_AAAA, TCK_DIV=2:
  - Expect ir_in=01, 1 vs_uir period, 1 vs_cdr period, 38 vs_sdr periods, 1 vs_udr period.
  - Expect rsp_valid 164 cycles after accept with rsp_data=38'h2A_AAAA_AAAA.
- tdo tied 1, cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF; tdi observed 0 on all 38 shifts.
- Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, second cmd_valid not accepted; rsp_ready=1 -> IDLE, then second command accepted.
- Reset asserted during SDR bit 17 -> outputs return to reset values immediately; next command with tdo=tdi and data 38'h12_3456_789A -> rsp_data=38'h12_3456_789A.
- TCK_DIV=1, tdo=tdi, data=38'h00_0000_0001 -> rsp_valid 82 cycles after accept, rsp_data=38'h00_0000_0001.
